// File: rtl/convolution.sv
// Valid-mode 2-D correlation engine: snapshots matrix/kernel on start, emits one output pixel per clock in raster order.
// Optional build macro CONV_RELU_EN clamps negative outputs to zero.
module convolution #(
  parameter int unsigned IMG_SIZE = 4,
  parameter int unsigned K_SIZE   = 2,
  parameter int unsigned DATA_W   = 8,
  parameter int unsigned OUT_W    = 32
) (
  input  logic                     clk,
  input  logic                     rst,
  input  logic                     start,
  input  logic signed [DATA_W-1:0] matrix [0:IMG_SIZE-1][0:IMG_SIZE-1],
  input  logic signed [DATA_W-1:0] kernel [0:K_SIZE-1][0:K_SIZE-1],
  output logic signed [OUT_W-1:0]  out_pixel,
  output logic                     out_valid,
  output logic                     done
);

  localparam int unsigned N      = IMG_SIZE - K_SIZE + 1;
  localparam int unsigned IDX_W  = (IMG_SIZE > 1) ? $clog2(IMG_SIZE) : 1;
  localparam int unsigned KIDX_W = (K_SIZE > 1) ? $clog2(K_SIZE) : 1;
  localparam int unsigned PROD_W = 2 * DATA_W;
  localparam logic [IDX_W-1:0] LAST = IDX_W'(N - 1);

  typedef enum logic [1:0] {
    IDLE    = 2'd0,
    COMPUTE = 2'd1,
    DONE    = 2'd2
  } state_t;

  state_t state, state_d;

  logic [IDX_W-1:0] x_cnt, x_cnt_d;
  logic [IDX_W-1:0] y_cnt, y_cnt_d;
  logic             out_valid_d;
  logic             done_d;
  logic signed [OUT_W-1:0] out_pixel_d;
  logic             load;

  logic signed [DATA_W-1:0] snap_m [0:IMG_SIZE-1][0:IMG_SIZE-1];
  logic signed [DATA_W-1:0] snap_k [0:K_SIZE-1][0:K_SIZE-1];

  logic signed [PROD_W-1:0] prod;
  logic signed [OUT_W-1:0]  acc;
  logic signed [OUT_W-1:0]  pix_c;

  // Multiply-accumulate over the kernel window anchored at (y_cnt, x_cnt)
  always_comb begin
    prod = '0;
    acc  = '0;
    for (int i = 0; i < int'(K_SIZE); i++) begin
      for (int j = 0; j < int'(K_SIZE); j++) begin
        prod = PROD_W'(snap_m[y_cnt + IDX_W'(i)][x_cnt + IDX_W'(j)])
             * PROD_W'(snap_k[KIDX_W'(i)][KIDX_W'(j)]);
        acc  = acc + OUT_W'(prod);
      end
    end
`ifdef CONV_RELU_EN
    pix_c = acc[OUT_W-1] ? '0 : acc;
`else
    pix_c = acc;
`endif
  end

  // Next-state and next-output logic
  always_comb begin
    state_d     = state;
    x_cnt_d     = x_cnt;
    y_cnt_d     = y_cnt;
    out_valid_d = 1'b0;
    done_d      = 1'b0;
    out_pixel_d = out_pixel;
    load        = 1'b0;
    unique case (state)
      IDLE: begin
        if (start) begin
          load    = 1'b1;
          x_cnt_d = '0;
          y_cnt_d = '0;
          state_d = COMPUTE;
        end
      end
      COMPUTE: begin
        out_valid_d = 1'b1;
        out_pixel_d = pix_c;
        if (x_cnt == LAST) begin
          x_cnt_d = '0;
          if (y_cnt == LAST) begin
            y_cnt_d = '0;
            state_d = DONE;
          end else begin
            y_cnt_d = y_cnt + IDX_W'(1);
          end
        end else begin
          x_cnt_d = x_cnt + IDX_W'(1);
        end
      end
      DONE: begin
        done_d  = 1'b1;
        state_d = IDLE;
      end
      default: state_d = IDLE;
    endcase
  end

  // State, output and snapshot registers
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state     <= IDLE;
      x_cnt     <= '0;
      y_cnt     <= '0;
      out_valid <= 1'b0;
      done      <= 1'b0;
      out_pixel <= '0;
      for (int r = 0; r < int'(IMG_SIZE); r++)
        for (int c = 0; c < int'(IMG_SIZE); c++)
          snap_m[r][c] <= '0;
      for (int r = 0; r < int'(K_SIZE); r++)
        for (int c = 0; c < int'(K_SIZE); c++)
          snap_k[r][c] <= '0;
    end else begin
      state     <= state_d;
      x_cnt     <= x_cnt_d;
      y_cnt     <= y_cnt_d;
      out_valid <= out_valid_d;
      done      <= done_d;
      out_pixel <= out_pixel_d;
      if (load) begin
        snap_m <= matrix;
        snap_k <= kernel;
      end
    end
  end

endmodule

// File: tb/tb_convolution.sv
// Directed self-checking bench for convolution: fixed vectors with hand-computed outputs and cycle-exact timing.
module tb_convolution;

  logic clk;
  logic rst;
  logic start;
  logic signed [7:0]  matrix [0:3][0:3];
  logic signed [7:0]  kernel [0:1][0:1];
  logic signed [31:0] out_pixel;
  logic               out_valid;
  logic               done;

  int n_pass  = 0;
  int n_total = 0;
  int expv [9];

  convolution #(.IMG_SIZE(4), .K_SIZE(2), .DATA_W(8), .OUT_W(32)) dut (
    .clk       (clk),
    .rst       (rst),
    .start     (start),
    .matrix    (matrix),
    .kernel    (kernel),
    .out_pixel (out_pixel),
    .out_valid (out_valid),
    .done      (done)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check(input string tag, input logic signed [31:0] got, input logic signed [31:0] exp);
    n_total++;
    if (got === exp) n_pass++;
    else $display("FAIL %s: got %0d expected %0d", tag, got, exp);
  endtask

  task automatic set_base_matrix();
    for (int r = 0; r < 4; r++)
      for (int c = 0; c < 4; c++)
        matrix[r][c] = 8'(r * 4 + c + 1);
  endtask

  task automatic set_kernel(input int k00, input int k01, input int k10, input int k11);
    kernel[0][0] = 8'(k00);
    kernel[0][1] = 8'(k01);
    kernel[1][0] = 8'(k10);
    kernel[1][1] = 8'(k11);
  endtask

  // Launch one run; when disturb is set, re-pulse start and zero the matrix mid-run.
  task automatic run_conv(input string tag, input bit disturb);
    start = 1'b1;
    @(posedge clk);
    #1;
    start = 1'b0;
    check($sformatf("%s_k0_valid", tag), 32'(out_valid), 0);
    check($sformatf("%s_k0_done", tag), 32'(done), 0);
    for (int k = 1; k <= 11; k++) begin
      @(posedge clk);
      #1;
      check($sformatf("%s_k%0d_valid", tag, k), 32'(out_valid), (k <= 9) ? 1 : 0);
      check($sformatf("%s_k%0d_done", tag, k), 32'(done), (k == 10) ? 1 : 0);
      if (k <= 9) check($sformatf("%s_pix%0d", tag, k - 1), out_pixel, expv[k - 1]);
      if (disturb) begin
        start = (k >= 2 && k <= 4);
        if (k == 3)
          for (int r = 0; r < 4; r++)
            for (int c = 0; c < 4; c++)
              matrix[r][c] = '0;
      end
    end
    start = 1'b0;
  endtask

  task automatic set_ones_expect();
    int ones [9] = '{14, 18, 22, 30, 34, 38, 46, 50, 54};
    for (int i = 0; i < 9; i++) expv[i] = ones[i];
  endtask

  initial begin
    rst   = 1'b0;
    start = 1'b0;
    set_base_matrix();
    set_kernel(0, 0, 0, 0);
    #12;
    check("rst_valid", 32'(out_valid), 0);
    check("rst_done", 32'(done), 0);
    check("rst_pixel", out_pixel, 0);
    @(negedge clk);
    rst = 1'b1;
    @(posedge clk);
    #1;

    // Diagonal difference kernel: every window gives m[y][x] - m[y+1][x+1] = -5
    set_kernel(1, 0, 0, -1);
    for (int i = 0; i < 9; i++) begin
`ifdef CONV_RELU_EN
      expv[i] = 0;
`else
      expv[i] = -5;
`endif
    end
    run_conv("diag", 1'b0);

    // Box kernel
    set_kernel(1, 1, 1, 1);
    set_ones_expect();
    run_conv("box", 1'b0);

    // Extreme negative operands: 4 * 16384
    for (int r = 0; r < 4; r++)
      for (int c = 0; c < 4; c++)
        matrix[r][c] = -8'sd128;
    set_kernel(-128, -128, -128, -128);
    for (int i = 0; i < 9; i++) expv[i] = 65536;
    run_conv("neg", 1'b0);

    // Start re-pulsed and matrix cleared mid-run: output must follow the snapshot
    set_base_matrix();
    set_kernel(1, 1, 1, 1);
    set_ones_expect();
    run_conv("dist", 1'b1);
    check("dist_pixel_hold", out_pixel, 54);

    // Reset after the 4th output
    set_base_matrix();
    start = 1'b1;
    @(posedge clk);
    #1;
    start = 1'b0;
    for (int k = 1; k <= 4; k++) begin
      @(posedge clk);
      #1;
      check($sformatf("abort_pix%0d", k - 1), out_pixel, expv[k - 1]);
    end
    #1;
    rst = 1'b0;
    #1;
    check("abort_valid", 32'(out_valid), 0);
    check("abort_done", 32'(done), 0);
    check("abort_pixel", out_pixel, 0);
    #3;
    rst = 1'b1;
    for (int k = 0; k < 12; k++) begin
      @(posedge clk);
      #1;
      check($sformatf("abort_quiet%0d_valid", k), 32'(out_valid), 0);
      check($sformatf("abort_quiet%0d_done", k), 32'(done), 0);
    end
    run_conv("fresh", 1'b0);

    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end

endmodule
